button_debounce: RTL and testbench

- Input-side counterpart to the LED driver: conditions the board's push-buttons into clean, clock-synchronous level and event signals for the user logic.
- Runs on the 1 MHz on-chip RC-oscillator clock.
- Per channel: a 2-FF synchronizer, a debounce FSM, and long-press detection.
- Button count matches the LED count (2) by default.

---
 rtl/button_debounce_pkg.sv | 10 +
 rtl/btn_channel.sv | 98 +++++++++
 rtl/button_debounce.sv | 31 +++
 tb/tb_button_debounce.sv | 100 ++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg: shared state encoding, default timing constants and counter sizing
package button_debounce_pkg;
    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} btn_state_t;
    localparam int DEF_N_BTN             = 2;
    localparam int DEF_DEBOUNCE_CYCLES   = 10000;
    localparam int DEF_LONG_PRESS_CYCLES = 1000000;
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction
endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchronizer, debounce fsm and long-press detection for one active-low button
module btn_channel
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_press
);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int LW = cnt_width(LONG_PRESS_CYCLES);
    logic sync1, sync2, s;
    btn_state_t state, state_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [LW-1:0] lcnt, lcnt_n;
    logic level_n, press_n, rel_n, long_n;
    logic holding;
    assign s = ~sync2;
    assign holding = (state == PRESSED) || (state == RELEASE_PEND);
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            state      <= RELEASED;
            dcnt       <= '0;
            lcnt       <= '0;
            level      <= 1'b0;
            press      <= 1'b0;
            rel        <= 1'b0;
            long_press <= 1'b0;
        end else begin
            sync1      <= btn_n;
            sync2      <= sync1;
            state      <= state_n;
            dcnt       <= dcnt_n;
            lcnt       <= lcnt_n;
            level      <= level_n;
            press      <= press_n;
            rel        <= rel_n;
            long_press <= long_n;
        end
    end
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        press_n = 1'b0;
        rel_n   = 1'b0;
        lcnt_n  = (holding && lcnt != LW'(LONG_PRESS_CYCLES)) ? lcnt + LW'(1) : lcnt;
        long_n  = holding && (lcnt == LW'(LONG_PRESS_CYCLES - 2));
        case (state)
            RELEASED: begin
                if (s) begin
                    state_n = PRESS_PEND;
                    dcnt_n  = DW'(1);
                end
            end
            PRESS_PEND: begin
                if (!s) begin
                    state_n = RELEASED;
                    dcnt_n  = '0;
                end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = PRESSED;
                    dcnt_n  = '0;
                    lcnt_n  = '0;
                    press_n = 1'b1;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_n = RELEASE_PEND;
                    dcnt_n  = DW'(1);
                end
            end
            RELEASE_PEND: begin
                if (s) begin
                    state_n = PRESSED;
                    dcnt_n  = '0;
                end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = RELEASED;
                    dcnt_n  = '0;
                    rel_n   = 1'b1;
                end else begin
                    dcnt_n = dcnt + DW'(1);
                end
            end
            default: state_n = RELEASED;
        endcase
        level_n = (state_n == PRESSED) || (state_n == RELEASE_PEND);
    end
endmodule

// File: rtl/button_debounce.sv
// button_debounce: independent debounced level, press, release and long-press outputs per button
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int N_BTN             = DEF_N_BTN,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] i_BTN,
    output logic [N_BTN-1:0] o_BTN_LEVEL,
    output logic [N_BTN-1:0] o_PRESS,
    output logic [N_BTN-1:0] o_RELEASE,
    output logic [N_BTN-1:0] o_LONG
);
    for (genvar g = 0; g < N_BTN; g++) begin : gen_ch
        btn_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn_n     (i_BTN[g]),
            .level     (o_BTN_LEVEL[g]),
            .press     (o_PRESS[g]),
            .rel       (o_RELEASE[g]),
            .long_press(o_LONG[g])
        );
    end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed checks of debounce, long-press and reset behaviour with short timing
module tb_button_debounce;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] i_BTN = 2'b11;
    logic [1:0] o_BTN_LEVEL, o_PRESS, o_RELEASE, o_LONG;
    logic [7:0] outs;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    button_debounce #(
        .N_BTN            (2),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_BTN      (i_BTN),
        .o_BTN_LEVEL(o_BTN_LEVEL),
        .o_PRESS    (o_PRESS),
        .o_RELEASE  (o_RELEASE),
        .o_LONG     (o_LONG)
    );
    // packed view: [7:6] long, [5:4] release, [3:2] press, [1:0] level
    assign outs = {o_LONG, o_RELEASE, o_PRESS, o_BTN_LEVEL};
    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        checks++;
        assert (outs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, outs, exp);
        end
    endtask
    task automatic run(input string tag, input int n, input logic [7:0] exp);
        for (int i = 0; i < n; i++) step(tag, exp);
    endtask
    initial begin
        reset = 1'b1;
        run("reset_hold", 3, 8'h00);
        reset = 1'b0;
        run("idle", 50, 8'h00);
        i_BTN = 2'b10;
        run("press0_wait", 5, 8'h00);
        step("press0", 8'h05);
        step("level0", 8'h01);
        i_BTN = 2'b11;
        run("rel0_wait", 5, 8'h01);
        step("rel0", 8'h10);
        step("rel0_after", 8'h00);
        repeat (5) begin
            i_BTN = 2'b10;
            run("bounce_low", 3, 8'h00);
            i_BTN = 2'b11;
            step("bounce_high", 8'h00);
        end
        run("bounce_settle", 4, 8'h00);
        i_BTN = 2'b01;
        run("press1_wait", 5, 8'h00);
        step("press1", 8'h0A);
        run("hold1", 18, 8'h02);
        step("long1", 8'h82);
        run("hold1_after_long", 15, 8'h02);
        i_BTN = 2'b11;
        run("rel1_wait", 5, 8'h02);
        step("rel1", 8'h20);
        step("rel1_after", 8'h00);
        i_BTN = 2'b00;
        run("both_wait", 5, 8'h00);
        step("press_both", 8'h0F);
        run("both_held", 2, 8'h03);
        i_BTN = 2'b01;
        run("rel0_start", 2, 8'h03);
        i_BTN = 2'b00;
        run("rel0_glitch", 2, 8'h03);
        i_BTN = 2'b01;
        run("rel0_retry", 5, 8'h03);
        step("rel0_delayed", 8'h12);
        run("ch1_hold", 6, 8'h02);
        step("long1_again", 8'h82);
        step("ch1_after_long", 8'h02);
        i_BTN = 2'b11;
        run("rel1_wait2", 5, 8'h02);
        step("rel1_again", 8'h20);
        step("all_idle", 8'h00);
        i_BTN = 2'b10;
        run("press0_wait2", 5, 8'h00);
        step("press0_again", 8'h05);
        step("level0_again", 8'h01);
        reset = 1'b1;
        run("reset_mid", 2, 8'h00);
        reset = 1'b0;
        run("post_reset_wait", 5, 8'h00);
        step("post_reset_press", 8'h05);
        step("post_reset_level", 8'h01);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
